// File: rtl/viterbi_frame_ctrl.sv
// rtl/viterbi_frame_ctrl.sv - encoder/decoder loopback frame sequencer (BER compare: VITERBI_CTRL_BER_EN)
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN = 256,
  parameter int TAIL_LEN  = 2,
  parameter int DEC_LAT   = 12,
  parameter int ERR_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             data_i,
  output logic             data_req_o,
  output logic             enc_en_o,
  output logic             enc_d_o,
  input  logic             dec_d_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  typedef enum logic [2:0] {IDLE, SEND, TAIL, DRAIN, DONE} state_t;

  // One phase counter serves SEND, TAIL and DRAIN; size it for the longest phase.
  localparam int MAXC = (FRAME_LEN > TAIL_LEN) ?
                        ((FRAME_LEN > DEC_LAT) ? FRAME_LEN : DEC_LAT) :
                        ((TAIL_LEN > DEC_LAT) ? TAIL_LEN : DEC_LAT);
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] F_LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TAIL_LEN - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DEC_LAT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          enc_en_q, enc_d_q;
  logic          start_acc;

  assign start_acc = (state_q == IDLE) && start_i;

  // State and phase counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; each phase ends when its counter reaches the last index.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_req_o = 1'b0;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        cnt_d  = '0;
        if (start_i) state_d = SEND;
      end
      SEND: begin
        data_req_o = 1'b1;
        if (cnt_q == F_LAST) begin
          state_d = TAIL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TAIL: begin
        if (cnt_q == T_LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == D_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Encoder drive: data bits during SEND, zero flush bits during TAIL, idle otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      enc_en_q <= 1'b0;
      enc_d_q  <= 1'b0;
    end else begin
      enc_en_q <= (state_q == SEND) || (state_q == TAIL);
      enc_d_q  <= (state_q == SEND) && data_i;
    end
  end

  assign enc_en_o = enc_en_q;
  assign enc_d_o  = enc_d_q;

`ifdef VITERBI_CTRL_BER_EN
  // Stage 0 mirrors enc_d_o; stage DEC_LAT lines up with the decoded bit on dec_d_i.
  logic [DEC_LAT:0] ref_v_q, ref_b_q;
  logic [ERR_W-1:0] err_q;

  // Reference line of transmitted bits; only SEND bits are marked valid.
  always_ff @(posedge clk) begin
    if (!rst || start_acc) begin
      ref_v_q <= '0;
      ref_b_q <= '0;
    end else begin
      ref_v_q <= {ref_v_q[DEC_LAT-1:0], state_q == SEND};
      ref_b_q <= {ref_b_q[DEC_LAT-1:0], (state_q == SEND) && data_i};
    end
  end

  // Saturating mismatch counter, cleared on accepted start.
  always_ff @(posedge clk) begin
    if (!rst || start_acc) begin
      err_q <= '0;
    end else if (ref_v_q[DEC_LAT] && (dec_d_i != ref_b_q[DEC_LAT]) && (err_q != '1)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign err_cnt_o = err_q;
`else
  logic unused_dec;
  assign unused_dec = dec_d_i;
  assign err_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb/tb_viterbi_frame_ctrl.sv - directed self-checking bench for viterbi_frame_ctrl
module tb_viterbi_frame_ctrl;
    localparam int F = 8;
    localparam int T = 2;
    localparam int L = 4;
`ifdef VITERBI_CTRL_BER_EN
    localparam bit BER = 1'b1;
`else
    localparam bit BER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start_i, data_i, dec_d_i, dec2;
    logic        data_req_o, enc_en_o, enc_d_o, busy_o, done_o;
    logic [15:0] err_cnt_o;
    logic        data_req2, enc_en2, enc_d2, busy2, done2;
    logic [1:0]  err2;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    viterbi_frame_ctrl #(.FRAME_LEN(F), .TAIL_LEN(T), .DEC_LAT(L), .ERR_W(16)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .data_i(data_i),
        .data_req_o(data_req_o), .enc_en_o(enc_en_o), .enc_d_o(enc_d_o),
        .dec_d_i(dec_d_i), .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o)
    );

    viterbi_frame_ctrl #(.FRAME_LEN(F), .TAIL_LEN(T), .DEC_LAT(L), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start_i(start_i), .data_i(data_i),
        .data_req_o(data_req2), .enc_en_o(enc_en2), .enc_d_o(enc_d2),
        .dec_d_i(dec2), .busy_o(busy2), .done_o(done2), .err_cnt_o(err2)
    );

    task automatic run_frame(input logic [7:0] d, input logic [7:0] flip, input bit hold,
                             input int exp_err, input int exp_err2);
        logic exp_req, exp_en, exp_d, exp_busy, exp_done;
        for (int c = 0; c < 16; c++) begin
            start_i = (c == 0) || hold;
            data_i  = (c >= 1 && c <= 8) ? d[8-c] : 1'($urandom_range(0, 1));
            if (c >= 6 && c <= 13) begin
                dec_d_i = d[13-c] ^ flip[13-c];
                dec2    = ~d[13-c];
            end else begin
                dec_d_i = 1'b1;
                dec2    = 1'b1;
            end
            exp_req  = (c >= 1 && c <= 8);
            exp_en   = (c >= 2 && c <= 11);
            exp_d    = (c >= 2 && c <= 9) ? d[9-c] : 1'b0;
            exp_busy = (c >= 1);
            exp_done = (c == 15);
            @(negedge clk);
            n_tests++;
            if (data_req_o !== exp_req) begin
                n_fail++;
                $error("FAIL data_req c=%0d: observed %0d expected %0d", c, data_req_o, exp_req);
            end
            n_tests++;
            if (enc_en_o !== exp_en) begin
                n_fail++;
                $error("FAIL enc_en c=%0d: observed %0d expected %0d", c, enc_en_o, exp_en);
            end
            n_tests++;
            if (enc_d_o !== exp_d) begin
                n_fail++;
                $error("FAIL enc_d c=%0d: observed %0d expected %0d", c, enc_d_o, exp_d);
            end
            n_tests++;
            if (busy_o !== exp_busy) begin
                n_fail++;
                $error("FAIL busy c=%0d: observed %0d expected %0d", c, busy_o, exp_busy);
            end
            n_tests++;
            if (done_o !== exp_done) begin
                n_fail++;
                $error("FAIL done c=%0d: observed %0d expected %0d", c, done_o, exp_done);
            end
            if (c == 1) begin
                n_tests++;
                if (err_cnt_o !== 16'd0) begin
                    n_fail++;
                    $error("FAIL err_clear: observed %0d expected 0", err_cnt_o);
                end
            end
            if (c == 15) begin
                n_tests++;
                if (err_cnt_o !== exp_err[15:0]) begin
                    n_fail++;
                    $error("FAIL err_final: observed %0d expected %0d", err_cnt_o, exp_err);
                end
                n_tests++;
                if (err2 !== exp_err2[1:0]) begin
                    n_fail++;
                    $error("FAIL err_sat: observed %0d expected %0d", err2, exp_err2);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] rflip;
        rst = 1'b0; start_i = 1'b0; data_i = 1'b0; dec_d_i = 1'b0; dec2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_tests++;
        if (enc_en_o !== 1'b0) begin
            n_fail++;
            $error("FAIL rst_enc_en: observed %0d expected 0", enc_en_o);
        end
        n_tests++;
        if (enc_d_o !== 1'b0) begin
            n_fail++;
            $error("FAIL rst_enc_d: observed %0d expected 0", enc_d_o);
        end
        n_tests++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $error("FAIL rst_busy: observed %0d expected 0", busy_o);
        end
        n_tests++;
        if (done_o !== 1'b0) begin
            n_fail++;
            $error("FAIL rst_done: observed %0d expected 0", done_o);
        end
        n_tests++;
        if (data_req_o !== 1'b0) begin
            n_fail++;
            $error("FAIL rst_req: observed %0d expected 0", data_req_o);
        end
        n_tests++;
        if (err_cnt_o !== 16'd0) begin
            n_fail++;
            $error("FAIL rst_err: observed %0d expected 0", err_cnt_o);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_frame(8'b10110010, 8'b00000000, 1'b0, 0, BER ? 3 : 0);
        run_frame(8'b10110010, 8'b00100101, 1'b0, BER ? 3 : 0, BER ? 3 : 0);

        rflip = 8'($urandom);
        run_frame(8'h5A, rflip, 1'b1, BER ? $countones(rflip) : 0, BER ? 3 : 0);
        run_frame(8'hC3, 8'h00, 1'b0, 0, BER ? 3 : 0);

        for (int c = 0; c < 7; c++) begin
            start_i = (c == 0);
            data_i  = 1'b1;
            dec_d_i = 1'b0;
            dec2    = 1'b0;
            rst     = (c != 5);
            @(negedge clk);
            if (c == 5) begin
                n_tests++;
                if (data_req_o !== 1'b1) begin
                    n_fail++;
                    $error("FAIL mid_req: observed %0d expected 1", data_req_o);
                end
            end
            if (c == 6) begin
                n_tests++;
                if (data_req_o !== 1'b0) begin
                    n_fail++;
                    $error("FAIL mid_rst_req: observed %0d expected 0", data_req_o);
                end
                n_tests++;
                if (enc_en_o !== 1'b0) begin
                    n_fail++;
                    $error("FAIL mid_rst_en: observed %0d expected 0", enc_en_o);
                end
                n_tests++;
                if (enc_d_o !== 1'b0) begin
                    n_fail++;
                    $error("FAIL mid_rst_d: observed %0d expected 0", enc_d_o);
                end
                n_tests++;
                if (busy_o !== 1'b0) begin
                    n_fail++;
                    $error("FAIL mid_rst_busy: observed %0d expected 0", busy_o);
                end
                n_tests++;
                if (done_o !== 1'b0) begin
                    n_fail++;
                    $error("FAIL mid_rst_done: observed %0d expected 0", done_o);
                end
                n_tests++;
                if (err_cnt_o !== 16'd0) begin
                    n_fail++;
                    $error("FAIL mid_rst_err: observed %0d expected 0", err_cnt_o);
                end
            end
            @(posedge clk);
            #1;
        end
        run_frame(8'hFF, 8'b10000001, 1'b0, BER ? 2 : 0, BER ? 3 : 0);
        run_frame(8'h00, 8'hFF, 1'b0, BER ? 8 : 0, BER ? 3 : 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
